interconn_arb: RTL and testbench

// N-port MVU-to-MVU interconnect, successor to interconn. Adds per-source input FIFOs with a

---
 rtl/interconn_arb.sv | 193 +++++++++++++++++++
 tb/tb_interconn_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interconn_arb.sv
// N-port MVU-to-MVU interconnect: per-source FIFOs, multicast delivery and
// per-destination round-robin arbitration into registered receive ports.
module interconn_arb #(
  parameter int N     = 8,
  parameter int W     = 64,
  parameter int BADDR = 15,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [N*N-1:0]     send_to,
  input  logic [N-1:0]       send_en,
  input  logic [N*BADDR-1:0] send_addr,
  input  logic [N*W-1:0]     send_word,
  output logic [N-1:0]       send_rdy,
  output logic [N-1:0]       send_ovf,
  output logic [N*N-1:0]     recv_from,
  output logic [N-1:0]       recv_en,
  output logic [N*BADDR-1:0] recv_addr,
  output logic [N*W-1:0]     recv_word
);

  localparam int LW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = N + BADDR + W;

  // Handshake: a word is accepted at a rising edge when send_en[i] and
  // send_rdy[i] are both high and its mask is non-zero; send_en[i] while
  // send_rdy[i] is low drops the word and latches send_ovf[i]. The receive
  // side has no ready: recv_en[j] is a one-cycle write strobe per word.

  // FIFO storage and bookkeeping
  logic [EW-1:0]    mem_q      [N][DEPTH];
  logic [PW-1:0]    wr_ptr_q   [N];
  logic [PW-1:0]    wr_ptr_d   [N];
  logic [PW-1:0]    rd_ptr_q   [N];
  logic [PW-1:0]    rd_ptr_d   [N];
  logic [CW-1:0]    cnt_q      [N];
  logic [CW-1:0]    cnt_d      [N];
  logic [N-1:0]     served_q   [N];
  logic [N-1:0]     served_d   [N];
  logic [N-1:0]     ovf_q;
  logic [N-1:0]     ovf_d;

  // Arbitration state
  logic [LW-1:0]    rr_q       [N];
  logic [LW-1:0]    rr_d       [N];

  // Receive registers
  logic [N-1:0]     recv_en_q;
  logic [N-1:0]     recv_en_d;
  logic [N-1:0]     recv_from_q [N];
  logic [N-1:0]     recv_from_d [N];
  logic [BADDR-1:0] recv_addr_q [N];
  logic [BADDR-1:0] recv_addr_d [N];
  logic [W-1:0]     recv_word_q [N];
  logic [W-1:0]     recv_word_d [N];

  // Combinational views
  logic [N-1:0]     full;
  logic [N-1:0]     nonempty;
  logic [N-1:0]     push;
  logic [N-1:0]     pop;
  logic [N-1:0]     head_mask  [N];
  logic [BADDR-1:0] head_addr  [N];
  logic [W-1:0]     head_word  [N];
  logic [N-1:0]     pend       [N];
  logic [N-1:0]     gnt_vld;
  logic [LW-1:0]    gnt_src    [N];
  logic [N-1:0]     src_gnt    [N];

  always_comb begin : source_side
    for (int i = 0; i < N; i++) begin
      full[i]      = (cnt_q[i] == CW'(DEPTH));
      nonempty[i]  = (cnt_q[i] != '0);
      head_mask[i] = mem_q[i][rd_ptr_q[i]][EW-1 -: N];
      head_addr[i] = mem_q[i][rd_ptr_q[i]][W +: BADDR];
      head_word[i] = mem_q[i][rd_ptr_q[i]][W-1:0];
      pend[i]      = nonempty[i] ? (head_mask[i] & ~served_q[i]) : '0;
      push[i]      = send_en[i] & ~full[i] & (send_to[i*N +: N] != '0);
    end
  end

  // Round-robin search per destination, starting at rr_q[j].
  always_comb begin : arbiter
    int idx;
    idx = 0;
    for (int j = 0; j < N; j++) begin
      gnt_vld[j] = 1'b0;
      gnt_src[j] = '0;
      for (int off = 0; off < N; off++) begin
        idx = (int'(rr_q[j]) + off) % N;
        if (!gnt_vld[j] && pend[idx][j]) begin
          gnt_vld[j] = 1'b1;
          gnt_src[j] = LW'(idx);
        end
      end
    end
  end

  always_comb begin : grant_transpose
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        src_gnt[i][j] = gnt_vld[j] && (gnt_src[j] == LW'(i));
      end
    end
  end

  // A head word retires only once every destination in its mask has been granted.
  always_comb begin : source_next
    for (int i = 0; i < N; i++) begin
      pop[i]      = nonempty[i] && ((served_q[i] | src_gnt[i]) == head_mask[i]);
      served_d[i] = pop[i] ? '0 : (served_q[i] | src_gnt[i]);
      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      ovf_d[i] = ovf_q[i] | (send_en[i] & full[i]);
    end
  end

  always_comb begin : dest_next
    for (int j = 0; j < N; j++) begin
      recv_en_d[j]   = gnt_vld[j];
      recv_from_d[j] = recv_from_q[j];
      recv_addr_d[j] = recv_addr_q[j];
      recv_word_d[j] = recv_word_q[j];
      rr_d[j]        = rr_q[j];
      if (gnt_vld[j]) begin
        recv_from_d[j] = N'(1) << gnt_src[j];
        recv_addr_d[j] = head_addr[gnt_src[j]];
        recv_word_d[j] = head_word[gnt_src[j]];
        rr_d[j]        = (gnt_src[j] == LW'(N-1)) ? '0 : gnt_src[j] + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ovf_q     <= '0;
      recv_en_q <= '0;
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i]    <= '0;
        rd_ptr_q[i]    <= '0;
        cnt_q[i]       <= '0;
        served_q[i]    <= '0;
        rr_q[i]        <= '0;
        recv_from_q[i] <= '0;
        recv_addr_q[i] <= '0;
        recv_word_q[i] <= '0;
      end
    end else begin
      ovf_q     <= ovf_d;
      recv_en_q <= recv_en_d;
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i]    <= wr_ptr_d[i];
        rd_ptr_q[i]    <= rd_ptr_d[i];
        cnt_q[i]       <= cnt_d[i];
        served_q[i]    <= served_d[i];
        rr_q[i]        <= rr_d[i];
        recv_from_q[i] <= recv_from_d[i];
        recv_addr_q[i] <= recv_addr_d[i];
        recv_word_q[i] <= recv_word_d[i];
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {send_to[i*N +: N], send_addr[i*BADDR +: BADDR],
                                  send_word[i*W +: W]};
      end
    end
  end

  always_comb begin : pack_outputs
    send_rdy = ~full;
    send_ovf = ovf_q;
    recv_en  = recv_en_q;
    for (int j = 0; j < N; j++) begin
      recv_from[j*N +: N]         = recv_from_q[j];
      recv_addr[j*BADDR +: BADDR] = recv_addr_q[j];
      recv_word[j*W +: W]         = recv_word_q[j];
    end
  end

endmodule

// File: tb/tb_interconn_arb.sv
// Directed bench for interconn_arb: unicast sweep, multicast, contention,
// overflow, multicast stall and asynchronous reset, checked with immediate assertions.
module tb_interconn_arb;

  localparam int N     = 8;
  localparam int W     = 64;
  localparam int BADDR = 15;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               clr_n = 1'b0;
  logic [N*N-1:0]     send_to = '0;
  logic [N-1:0]       send_en = '0;
  logic [N*BADDR-1:0] send_addr = '0;
  logic [N*W-1:0]     send_word = '0;
  logic [N-1:0]       send_rdy;
  logic [N-1:0]       send_ovf;
  logic [N*N-1:0]     recv_from;
  logic [N-1:0]       recv_en;
  logic [N*BADDR-1:0] recv_addr;
  logic [N*W-1:0]     recv_word;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] exp_src_q[$];

  interconn_arb #(.N(N), .W(W), .BADDR(BADDR), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .send_to   (send_to),
    .send_en   (send_en),
    .send_addr (send_addr),
    .send_word (send_word),
    .send_rdy  (send_rdy),
    .send_ovf  (send_ovf),
    .recv_from (recv_from),
    .recv_en   (recv_en),
    .recv_addr (recv_addr),
    .recv_word (recv_word)
  );

  // Clock and sampling: inputs change and outputs are sampled 1 ns after each rising edge.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    send_en   = '0;
    send_to   = '0;
    send_addr = '0;
    send_word = '0;
  endtask

  task automatic drive(input int src, input logic [N-1:0] mask,
                       input logic [BADDR-1:0] addr, input logic [W-1:0] word);
    send_en[src]                 = 1'b1;
    send_to[src*N +: N]          = mask;
    send_addr[src*BADDR +: BADDR] = addr;
    send_word[src*W +: W]        = word;
  endtask

  function automatic logic [N-1:0] from_of(input int j);
    return recv_from[j*N +: N];
  endfunction

  function automatic logic [W-1:0] word_of(input int j);
    return recv_word[j*W +: W];
  endfunction

  function automatic logic [BADDR-1:0] addr_of(input int j);
    return recv_addr[j*BADDR +: BADDR];
  endfunction

  task automatic unicast_sweep(input string pfx);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i != j) begin
          m = N'(1) << j;
          clear_inputs();
          drive(i, m, 15'd7, 64'hdeadbeefdeadbeef);
          tick();
          clear_inputs();
          chk($sformatf("%s_lat_%0d_%0d", pfx, i, j), recv_en, '0);
          tick();
          chk($sformatf("%s_en_%0d_%0d", pfx, i, j), recv_en, m);
          chk($sformatf("%s_from_%0d_%0d", pfx, i, j), from_of(j), N'(1) << i);
          chk($sformatf("%s_addr_%0d_%0d", pfx, i, j), addr_of(j), 15'd7);
          chk($sformatf("%s_word_%0d_%0d", pfx, i, j), word_of(j), 64'hdeadbeefdeadbeef);
        end
      end
    end
    tick();
  endtask

  initial begin
    int srcs[3];
    int delivered;
    srcs = '{0, 1, 3};

    // Reset state
    clear_inputs();
    tick();
    tick();
    chk("rst_recv_en", recv_en, '0);
    chk("rst_ovf", send_ovf, '0);
    chk("rst_from", recv_from, '0);
    chk("rst_word_zero", recv_word == '0, 1'b1);
    clr_n = 1'b1;
    tick();
    chk("rst_rdy", send_rdy, 8'hff);

    // Unicast sweep over every source/destination pair
    unicast_sweep("uc");

    // Contention: sources 0,1,3 to dest 5 for four cycles; grant order 0,1,3 repeating
    exp_q.delete();
    exp_src_q.delete();
    for (int k = 0; k < 4; k++) begin
      foreach (srcs[s]) begin
        exp_q.push_back({8'h05, 40'h0, 8'(srcs[s]), 8'(k)});
        exp_src_q.push_back(N'(1) << srcs[s]);
      end
    end
    delivered = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      clear_inputs();
      if (cyc < 4) begin
        foreach (srcs[s]) drive(srcs[s], 8'h20, 15'd5, {8'h05, 40'h0, 8'(srcs[s]), 8'(cyc)});
      end
      tick();
      if (recv_en[5]) begin
        delivered++;
        if (exp_q.size() == 0) begin
          chk("ct_extra", 64'(exp_q.size()), 64'd1);
        end else begin
          chk($sformatf("ct_from_%0d", delivered), from_of(5), exp_src_q.pop_front());
          chk($sformatf("ct_word_%0d", delivered), word_of(5), exp_q.pop_front());
        end
      end
    end
    chk("ct_count", 64'(delivered), 64'd12);
    chk("ct_left", 64'(exp_q.size()), 64'd0);

    // Multicast: source 2 to dests 0,4,5,7 in one cycle, popped once
    clear_inputs();
    drive(2, 8'b1011_0001, 15'h33, 64'h1234);
    tick();
    clear_inputs();
    chk("mc_lat", recv_en, '0);
    tick();
    chk("mc_en", recv_en, 8'hb1);
    foreach (srcs[s]) begin end
    for (int j = 0; j < N; j++) begin
      if (j == 0 || j == 4 || j == 5 || j == 7) begin
        chk($sformatf("mc_from_%0d", j), from_of(j), 8'h04);
        chk($sformatf("mc_word_%0d", j), word_of(j), 64'h1234);
        chk($sformatf("mc_addr_%0d", j), addr_of(j), 15'h33);
      end
    end
    tick();
    chk("mc_once", recv_en, '0);

    // Back-pressure: sources 0-5 flood dest 6 while source 7 pushes six words
    exp_q.delete();
    delivered = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      clear_inputs();
      for (int s = 0; s < 6; s++) drive(s, 8'h40, 15'(s), {8'h06, 48'h0, 8'(s)});
      drive(7, 8'h40, 15'h77, 64'h7700 + 64'(cyc));
      if (cyc < 4) exp_q.push_back(64'h7700 + 64'(cyc));
      tick();
      if (cyc == 2) chk("bp_rdy_3q", send_rdy[7], 1'b1);
      if (cyc == 3) begin
        chk("bp_rdy_full", send_rdy[7], 1'b0);
        chk("bp_ovf_clean", send_ovf[7], 1'b0);
      end
      if (cyc == 4) chk("bp_ovf_set", send_ovf[7], 1'b1);
      if (recv_en[6] && from_of(6) == 8'h80) begin
        delivered++;
        chk("bp_early", 64'(delivered), 64'd0);
      end
    end
    clear_inputs();
    for (int cyc = 0; cyc < 50; cyc++) begin
      tick();
      if (recv_en[6] && from_of(6) == 8'h80) begin
        delivered++;
        if (exp_q.size() == 0) chk("bp_extra", 64'(exp_q.size()), 64'd1);
        else chk($sformatf("bp_word_%0d", delivered), word_of(6), exp_q.pop_front());
      end
    end
    chk("bp_count", 64'(delivered), 64'd4);
    chk("bp_ovf_sticky", send_ovf[7], 1'b1);
    chk("bp_rdy_drained", send_rdy[7], 1'b1);

    // Mixed multicast stall: source 0 to {1,2} loses dest 2 to source 3 first
    drive(1, 8'h04, 15'h11, 64'h1111);
    tick();
    clear_inputs();
    tick();
    chk("mx_pre_en", recv_en, 8'h04);
    chk("mx_pre_from", from_of(2), 8'h02);
    tick();
    drive(0, 8'h06, 15'h0a, 64'haaaa);
    drive(3, 8'h04, 15'h0c, 64'hc001);
    tick();
    clear_inputs();
    drive(0, 8'h02, 15'h0b, 64'hbbbb);
    drive(3, 8'h04, 15'h0c, 64'hc002);
    chk("mx_lat", recv_en, '0);
    tick();
    chk("mx_c1_en", recv_en, 8'h06);
    chk("mx_c1_from1", from_of(1), 8'h01);
    chk("mx_c1_word1", word_of(1), 64'haaaa);
    chk("mx_c1_from2", from_of(2), 8'h08);
    chk("mx_c1_word2", word_of(2), 64'hc001);
    clear_inputs();
    drive(3, 8'h04, 15'h0c, 64'hc003);
    tick();
    clear_inputs();
    chk("mx_c2_en", recv_en, 8'h04);
    chk("mx_c2_from2", from_of(2), 8'h01);
    chk("mx_c2_word2", word_of(2), 64'haaaa);
    tick();
    chk("mx_c3_en", recv_en, 8'h06);
    chk("mx_c3_word1", word_of(1), 64'hbbbb);
    chk("mx_c3_from2", from_of(2), 8'h08);
    chk("mx_c3_word2", word_of(2), 64'hc002);
    tick();
    chk("mx_c4_en", recv_en, 8'h04);
    chk("mx_c4_word2", word_of(2), 64'hc003);
    tick();
    chk("mx_idle", recv_en, '0);

    // Asynchronous reset with FIFOs partly full
    for (int cyc = 0; cyc < 3; cyc++) begin
      clear_inputs();
      for (int s = 0; s < 4; s++) drive(s, 8'h10, 15'h4, {60'hbad, 4'(s)});
      tick();
    end
    clear_inputs();
    chk("ar_busy", recv_en[4], 1'b1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("ar_en", recv_en, '0);
    chk("ar_from", recv_from, '0);
    chk("ar_addr_zero", recv_addr == '0, 1'b1);
    chk("ar_word_zero", recv_word == '0, 1'b1);
    chk("ar_ovf", send_ovf, '0);
    #1;
    clr_n = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      chk($sformatf("ar_stale_%0d", cyc), recv_en, '0);
    end
    chk("ar_rdy", send_rdy, 8'hff);
    unicast_sweep("uc2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
